// File: rtl/imem_loader.sv
// Framed-image loader: parses LEN_HI, LEN_LO, 3 bytes/word, checksum; writes words to instruction memory.
// Latency: mem_we pulses 1 cycle after the third byte of a word is accepted; up to 1 byte/cycle.
// Backpressure: in_ready is high only while a load is parsing (LEN_HI..CHECK); bytes are ignored otherwise.
module imem_loader #(
    parameter int ADDR_W        = 12,
    parameter int IW            = 19,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [IW-1:0]     mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal image length: exactly fills the memory.
    localparam logic [16:0] CAP = 17'd1 << ADDR_W;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                do_start;
    logic                err_set;
    logic [1:0]          err_code;
    logic                wr_word;

    logic [7:0]          len_hi_q;
    logic [15:0]         len_q;
    logic [15:0]         len_full;
    logic                too_long;
    logic                last_word;
    logic [1:0]          bidx;
    logic [2:0]          b0_q;
    logic [7:0]          b1_q;
    logic [7:0]          csum;
    logic [ADDR_W-1:0]   addr;
    logic                we_q;

    assign len_full  = {len_hi_q, in_data};
    assign too_long  = ({1'b0, len_full} > CAP);
    assign last_word = ((17'(words_written) + 17'd1) == {1'b0, len_q});

    // Reset must kill an in-flight write immediately, not at the next edge.
    assign mem_we = we_q & ~rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, handshake outputs and event strobes for the datapath.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHECK);
        busy      = in_ready;
        accept    = in_valid & in_ready;
        do_start  = 1'b0;
        err_set   = 1'b0;
        err_code  = 2'd0;
        wr_word   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (too_long) begin
                        state_nxt = S_ERR;
                        err_set   = 1'b1;
                        err_code  = 2'd1;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    if ((bidx == 2'd0) && (in_data[7:3] != 5'd0)) begin
                        state_nxt = S_ERR;
                        err_set   = 1'b1;
                        err_code  = 2'd2;
                    end else if (bidx == 2'd2) begin
                        wr_word = 1'b1;
                        // Leave DATA on the same edge the write launches so the
                        // checksum byte can be taken during the write cycle.
                        if (last_word) state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == csum) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                        err_set   = 1'b1;
                        err_code  = 2'd3;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write launch, checksum and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi_q      <= 8'd0;
            len_q         <= 16'd0;
            bidx          <= 2'd0;
            b0_q          <= 3'd0;
            b1_q          <= 8'd0;
            csum          <= 8'd0;
            addr          <= '0;
            we_q          <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cpu_hold      <= HOLD_AT_RESET;
            done          <= 1'b0;
            error         <= 2'd0;
            words_written <= '0;
        end else begin
            we_q <= 1'b0;

            if (do_start) begin
                cpu_hold      <= 1'b1;
                done          <= 1'b0;
                error         <= 2'd0;
                words_written <= '0;
                csum          <= 8'd0;
                addr          <= '0;
            end

            if (accept) csum <= csum ^ in_data;

            if (accept && (state == S_LEN_HI)) len_hi_q <= in_data;

            if (accept && (state == S_LEN_LO)) begin
                len_q <= len_full;
                bidx  <= 2'd0;
            end

            if (accept && (state == S_DATA)) begin
                case (bidx)
                    2'd0:    begin b0_q <= in_data[2:0]; bidx <= 2'd1; end
                    2'd1:    begin b1_q <= in_data;      bidx <= 2'd2; end
                    default: bidx <= 2'd0;
                endcase
            end

            if (wr_word) begin
                we_q          <= 1'b1;
                mem_addr      <= addr;
                mem_wdata     <= {b0_q, b1_q, in_data};
                addr          <= addr + 1'b1;
                words_written <= words_written + 1'b1;
            end

            if ((state == S_CHECK) && (state_nxt == S_DONE)) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end

            if (err_set) error <= err_code;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4 so the length and wrap boundaries are reachable).
// Frame vectors run from a table; reset, mid-load start, async reset and full-memory load are hand sequences.
// The write port is captured into a bench-side memory and compared with hand-computed words.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [18:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic [1:0]    error;
    logic [AW:0]   words_written;

    int n_chk  = 0;
    int n_fail = 0;

    logic [18:0] tb_mem [0:15];
    int          we_cnt;
    logic        clr_mem = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW), .IW(19), .HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    // Memory model: commits whatever the write port presents at each rising edge.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) tb_mem[i] = 19'h0;
            we_cnt = 0;
        end else if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            we_cnt++;
        end
    end

    typedef struct {
        string       name;
        int          nb;
        logic [95:0] data;   // frame bytes, right-aligned, first byte most significant
        bit          gaps;
        logic [1:0]  e_err;
        logic        e_done;
        logic        e_hold;
        logic [4:0]  e_ww;
        int          e_we;
        logic [18:0] e_m0;
        logic [18:0] e_m1;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] vbyte(input logic [95:0] d, input int nb, input int i);
        logic [95:0] t;
        t = d >> (8 * (nb - 1 - i));
        return t[7:0];
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"},    32'(mem_wdata), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_ww"},       32'(words_written), 32'd0);
    endtask

    // Standard two-word image; checksum 00^02^01^23^45^06^78^9A = 0x81.
    task automatic send_image1();
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0); send_byte(8'h45, 1'b0);
        send_byte(8'h06, 1'b0); send_byte(8'h78, 1'b0); send_byte(8'h9A, 1'b0);
        send_byte(8'h81, 1'b0);
    endtask

    initial begin
        logic [18:0] exp_w [0:15];
        logic [7:0]  cs;
        logic [7:0]  b0, b1, b2;

        vt[0] = '{"two_words",   9, 96'h00_02_01_23_45_06_78_9A_81, 1'b0, 2'd0, 1'b1, 1'b0, 5'd2, 2, 19'h12345, 19'h6789A};
        vt[1] = '{"bad_csum",    9, 96'h00_02_01_23_45_06_78_9A_00, 1'b0, 2'd3, 1'b0, 1'b1, 5'd2, 2, 19'h12345, 19'h6789A};
        vt[2] = '{"zero_len",    3, 96'h00_00_00,                   1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 0, 19'h0,     19'h0};
        vt[3] = '{"len_17",      2, 96'h00_11,                      1'b0, 2'd1, 1'b0, 1'b1, 5'd0, 0, 19'h0,     19'h0};
        vt[4] = '{"len_256",     2, 96'h01_00,                      1'b0, 2'd1, 1'b0, 1'b1, 5'd0, 0, 19'h0,     19'h0};
        vt[5] = '{"fmt_first",   3, 96'h00_01_08,                   1'b0, 2'd2, 1'b0, 1'b1, 5'd0, 0, 19'h0,     19'h0};
        vt[6] = '{"gaps",        9, 96'h00_02_01_23_45_06_78_9A_81, 1'b1, 2'd0, 1'b1, 1'b0, 5'd2, 2, 19'h12345, 19'h6789A};
        // 00^01^07^FF^FF = 0x06
        vt[7] = '{"max_word",    6, 96'h00_01_07_FF_FF_06,          1'b0, 2'd0, 1'b1, 1'b0, 5'd1, 1, 19'h7FFFF, 19'h0};
        vt[8] = '{"fmt_second",  6, 96'h00_02_01_23_45_F0,          1'b0, 2'd2, 1'b0, 1'b1, 5'd1, 1, 19'h12345, 19'h0};

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1 rst = 1'b1;
        tick(); tick();
        check_reset_vals("rst_held");
        rst = 1'b0;
        tick();
        check_reset_vals("rst_released");

        // Table-driven frames.
        for (int v = 0; v < 9; v++) begin
            clear_mem();
            pulse_start();
            check({vt[v].name, "_after_start"},
                  32'({busy, in_ready, done, error, cpu_hold, words_written}),
                  32'({1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 5'd0}));
            for (int i = 0; i < vt[v].nb; i++) send_byte(vbyte(vt[v].data, vt[v].nb, i), vt[v].gaps);
            // Offered bytes while not ready must change nothing.
            in_valid = 1'b1;
            in_data  = 8'h5A;
            repeat (3) tick();
            in_valid = 1'b0;
            tick();
            check({vt[v].name, "_error"},    32'(error),         32'(vt[v].e_err));
            check({vt[v].name, "_done"},     32'(done),          32'(vt[v].e_done));
            check({vt[v].name, "_cpu_hold"}, 32'(cpu_hold),      32'(vt[v].e_hold));
            check({vt[v].name, "_ww"},       32'(words_written), 32'(vt[v].e_ww));
            check({vt[v].name, "_we_count"}, 32'(we_cnt),        32'(vt[v].e_we));
            check({vt[v].name, "_idle_rdy"}, 32'({busy, in_ready}), 32'd0);
            if (vt[v].e_we >= 1) check({vt[v].name, "_mem0"}, 32'(tb_mem[0]), 32'(vt[v].e_m0));
            if (vt[v].e_we >= 2) check({vt[v].name, "_mem1"}, 32'(tb_mem[1]), 32'(vt[v].e_m1));
        end

        // start pulsed in the middle of a load is ignored.
        clear_mem();
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h01, 1'b0);
        pulse_start();
        send_byte(8'h23, 1'b0); send_byte(8'h45, 1'b0);
        send_byte(8'h06, 1'b0); send_byte(8'h78, 1'b0); send_byte(8'h9A, 1'b0);
        send_byte(8'h81, 1'b0);
        tick();
        check("midstart_done", 32'(done), 32'd1);
        check("midstart_mem0", 32'(tb_mem[0]), 32'h12345);
        check("midstart_mem1", 32'(tb_mem[1]), 32'h6789A);

        // Reset asserted while a write is being presented.
        clear_mem();
        pulse_start();
        send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0); send_byte(8'h45, 1'b0);
        check("inflight_we",    32'(mem_we),    32'd1);
        check("inflight_wdata", 32'(mem_wdata), 32'h12345);
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("dropped_write", 32'(we_cnt), 32'd0);
        clear_mem();
        pulse_start();
        send_image1();
        tick();
        check("post_rst_done", 32'(done),     32'd1);
        check("post_rst_hold", 32'(cpu_hold), 32'd0);
        check("post_rst_mem0", 32'(tb_mem[0]), 32'h12345);
        check("post_rst_mem1", 32'(tb_mem[1]), 32'h6789A);

        // Full-capacity image: 16 words, last write at address 15.
        clear_mem();
        pulse_start();
        cs = 8'h00;
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        cs = 8'h10;
        for (int i = 0; i < 16; i++) begin
            b0 = 8'(i & 7);
            b1 = 8'(i * 17);
            b2 = 8'(i) ^ 8'hA5;
            exp_w[i] = {b0[2:0], b1, b2};
            cs = cs ^ b0 ^ b1 ^ b2;
            send_byte(b0, 1'b0); send_byte(b1, 1'b0); send_byte(b2, 1'b0);
        end
        send_byte(cs, 1'b0);
        tick();
        check("full_done",     32'(done),          32'd1);
        check("full_ww",       32'(words_written), 32'd16);
        check("full_we_count", 32'(we_cnt),        32'd16);
        check("full_last_addr", 32'(mem_addr),     32'd15);
        for (int i = 0; i < 16; i++) check($sformatf("full_mem%0d", i), 32'(tb_mem[i]), 32'(exp_w[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
